// File: rtl/ext_int_pkg.sv
// Shared types and constants for the external interrupt controller:
// FSM state encoding, register map addresses and detector sense codes.
package ext_int_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    localparam logic [1:0] ADDR_ENABLE  = 2'd0;
    localparam logic [1:0] ADDR_PENDING = 2'd1;
    localparam logic [1:0] ADDR_CTRL    = 2'd2;
    localparam logic [1:0] ADDR_SENSE   = 2'd3;

    localparam logic [1:0] RISE   = 2'b00;
    localparam logic [1:0] FALL   = 2'b01;
    localparam logic [1:0] CHANGE = 2'b10;

endpackage

// File: rtl/int_priority_encoder.sv
// Lowest-index-first priority encoder: id is the index of the lowest set
// request bit; valid is high when any request bit is set.
module int_priority_encoder #(
    parameter int NUM_SRC = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_SRC-1:0] req,
    output logic               valid,
    output logic [ID_W-1:0]    id
);

    always_comb begin
        valid = |req;
        id    = '0;
        // Scan from the top down so the lowest set index is written last.
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                id = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/ext_int_controller.sv
// Configuration registers, pending latch and request/ack/done handshake for
// up to four external interrupt edge detectors.
module ext_int_controller
    import ext_int_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int ID_W    = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_SRC-1:0]     src_req,
    input  logic                   cfg_wr_en,
    input  logic [1:0]             cfg_addr,
    input  logic [7:0]             cfg_wdata,
    output logic [7:0]             cfg_rdata,
    output logic [NUM_SRC-1:0]     int_enable,
    output logic [2*NUM_SRC-1:0]   int_sense,
    output logic [NUM_SRC-1:0]     int_debounce,
    output logic                   irq,
    output logic [ID_W-1:0]        irq_id,
    input  logic                   irq_ack,
    input  logic                   irq_done,
    output logic [1:0]             state_dbg
);

    // Handshake: irq is held high in REQ until the core pulses irq_ack
    // (accepted, pending bit cleared) or the request is withdrawn because GIE
    // or the source enable dropped; irq_done is honoured only in SERVICE.

    state_t                 state_q;
    logic [NUM_SRC-1:0]     enable_q;
    logic [NUM_SRC-1:0]     pending_q;
    logic [NUM_SRC-1:0]     debounce_q;
    logic [2*NUM_SRC-1:0]   sense_q;
    logic                   gie_q;

    logic                   wr_enable;
    logic                   wr_pending;
    logic                   wr_ctrl;
    logic                   wr_sense;
    logic [NUM_SRC-1:0]     w1c_mask;
    logic [NUM_SRC-1:0]     ack_mask;
    logic [NUM_SRC-1:0]     pending_d;
    logic [NUM_SRC-1:0]     eligible;
    logic                   win_valid;
    logic [ID_W-1:0]        win_id;
    logic                   ack_take;
    logic                   withdraw;

    logic [3:0]             en_pad;
    logic [3:0]             pend_pad;
    logic [3:0]             dbn_pad;
    logic [7:0]             sense_pad;

    // Zero-extended copies make readback and irq_id indexing independent of NUM_SRC.
    always_comb begin
        en_pad                     = '0;
        pend_pad                   = '0;
        dbn_pad                    = '0;
        sense_pad                  = '0;
        en_pad[NUM_SRC-1:0]        = enable_q;
        pend_pad[NUM_SRC-1:0]      = pending_q;
        dbn_pad[NUM_SRC-1:0]       = debounce_q;
        sense_pad[2*NUM_SRC-1:0]   = sense_q;
    end

    assign wr_enable  = cfg_wr_en && (cfg_addr == ADDR_ENABLE);
    assign wr_pending = cfg_wr_en && (cfg_addr == ADDR_PENDING);
    assign wr_ctrl    = cfg_wr_en && (cfg_addr == ADDR_CTRL);
    assign wr_sense   = cfg_wr_en && (cfg_addr == ADDR_SENSE);

    assign ack_take = (state_q == REQ) && irq_ack;
    assign withdraw = (state_q == REQ) && !irq_ack && (!gie_q || !en_pad[irq_id]);

    always_comb begin
        w1c_mask = wr_pending ? cfg_wdata[NUM_SRC-1:0] : '0;
        ack_mask = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            ack_mask[i] = ack_take && (irq_id == ID_W'(i));
        end
        // A new pulse on the same bit as a clear wins.
        pending_d = (pending_q & ~(w1c_mask | ack_mask)) | src_req;
    end

    assign eligible = pending_q & enable_q & {NUM_SRC{gie_q}};

    int_priority_encoder #(
        .NUM_SRC (NUM_SRC),
        .ID_W    (ID_W)
    ) u_prio (
        .req     (eligible),
        .valid   (win_valid),
        .id      (win_id)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            enable_q   <= '0;
            pending_q  <= '0;
            debounce_q <= '0;
            sense_q    <= '0;
            gie_q      <= 1'b0;
        end else begin
            pending_q <= pending_d;
            if (wr_enable) begin
                enable_q <= cfg_wdata[NUM_SRC-1:0];
            end
            if (wr_ctrl) begin
                gie_q      <= cfg_wdata[0];
                debounce_q <= cfg_wdata[4 +: NUM_SRC];
            end
            if (wr_sense) begin
                sense_q <= cfg_wdata[2*NUM_SRC-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            irq     <= 1'b0;
            irq_id  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (win_valid) begin
                        state_q <= REQ;
                        irq     <= 1'b1;
                        irq_id  <= win_id;
                    end else begin
                        irq <= 1'b0;
                    end
                end
                REQ: begin
                    if (ack_take) begin
                        state_q <= SERVICE;
                        irq     <= 1'b0;
                    end else if (withdraw) begin
                        state_q <= IDLE;
                        irq     <= 1'b0;
                    end else begin
                        irq <= 1'b1;
                    end
                end
                SERVICE: begin
                    irq <= 1'b0;
                    if (irq_done) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    irq     <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        cfg_rdata = '0;
        case (cfg_addr)
            ADDR_ENABLE:  cfg_rdata = {4'b0000, en_pad};
            ADDR_PENDING: cfg_rdata = {4'b0000, pend_pad};
            ADDR_CTRL:    cfg_rdata = {dbn_pad, 3'b000, gie_q};
            ADDR_SENSE:   cfg_rdata = sense_pad;
            default:      cfg_rdata = '0;
        endcase
    end

    assign int_enable   = enable_q;
    assign int_sense    = sense_q;
    assign int_debounce = debounce_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_ext_int_controller.sv
// Directed bench for ext_int_controller: expected values are queued when the
// stimulus is applied and popped as the matching DUT output is sampled.
module tb_ext_int_controller;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_REQ     = 2'd1;
    localparam logic [1:0] S_SERVICE = 2'd2;

    logic       clk;
    logic       rst_n;
    logic [3:0] src_req;
    logic       cfg_wr_en;
    logic [1:0] cfg_addr;
    logic [7:0] cfg_wdata;
    logic [7:0] cfg_rdata;
    logic [3:0] int_enable;
    logic [7:0] int_sense;
    logic [3:0] int_debounce;
    logic       irq;
    logic [1:0] irq_id;
    logic       irq_ack;
    logic       irq_done;
    logic [1:0] state_dbg;

    logic [7:0] exp_q[$];
    int         n_cmp;
    int         n_bad;

    ext_int_controller #(
        .NUM_SRC (4),
        .ID_W    (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .src_req      (src_req),
        .cfg_wr_en    (cfg_wr_en),
        .cfg_addr     (cfg_addr),
        .cfg_wdata    (cfg_wdata),
        .cfg_rdata    (cfg_rdata),
        .int_enable   (int_enable),
        .int_sense    (int_sense),
        .int_debounce (int_debounce),
        .irq          (irq),
        .irq_id       (irq_id),
        .irq_ack      (irq_ack),
        .irq_done     (irq_done),
        .state_dbg    (state_dbg)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks: inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [7:0] d);
        cfg_wr_en = 1'b1;
        cfg_addr  = a;
        cfg_wdata = d;
        tick();
        cfg_wr_en = 1'b0;
        cfg_wdata = 8'h00;
    endtask

    task automatic cfg_read(input logic [1:0] a, output logic [7:0] d);
        cfg_addr = a;
        #1;
        d = cfg_rdata;
    endtask

    // Scoreboard
    task automatic expect_v(input logic [7:0] v);
        exp_q.push_back(v);
    endtask

    task automatic compare(input string tag, input logic [7:0] obs);
        logic [7:0] exp_v;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $error("FAIL %s: observed %0h but scoreboard queue is empty", tag, obs);
        end else begin
            exp_v = exp_q.pop_front();
            assert (obs === exp_v) else begin
                n_bad++;
                $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        expect_v(exp_v);
        compare(tag, obs);
    endtask

    task automatic chk_reg(input string tag, input logic [1:0] a, input logic [7:0] exp_v);
        logic [7:0] d;
        expect_v(exp_v);
        cfg_read(a, d);
        compare(tag, d);
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        rst_n     = 1'b0;
        src_req   = '0;
        cfg_wr_en = 1'b0;
        cfg_addr  = 2'd0;
        cfg_wdata = 8'h00;
        irq_ack   = 1'b0;
        irq_done  = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;

        // Reset state
        chk("rst_irq", {7'd0, irq}, 8'h00);
        chk("rst_irq_id", {6'd0, irq_id}, 8'h00);
        chk("rst_enable", {4'd0, int_enable}, 8'h00);
        chk("rst_sense", int_sense, 8'h00);
        chk("rst_debounce", {4'd0, int_debounce}, 8'h00);
        chk("rst_state", {6'd0, state_dbg}, {6'd0, S_IDLE});
        chk_reg("rst_pending", 2'd1, 8'h00);
        chk_reg("rst_ctrl", 2'd2, 8'h00);

        // Basic handshake
        cfg_write(2'd0, 8'h01);
        cfg_write(2'd2, 8'h01);
        src_req = 4'b0001;
        tick();
        src_req = '0;
        chk_reg("basic_pend_t1", 2'd1, 8'h01);
        chk("basic_irq_t1", {7'd0, irq}, 8'h00);
        tick();
        chk("basic_irq_t2", {7'd0, irq}, 8'h01);
        chk("basic_id_t2", {6'd0, irq_id}, 8'h00);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        chk("basic_irq_ack", {7'd0, irq}, 8'h00);
        chk_reg("basic_pend_ack", 2'd1, 8'h00);
        chk("basic_state_svc", {6'd0, state_dbg}, {6'd0, S_SERVICE});
        irq_done = 1'b1;
        tick();
        irq_done = 1'b0;
        chk("basic_state_done", {6'd0, state_dbg}, {6'd0, S_IDLE});

        // Priority: sources 3 and 1 together, lowest index first
        cfg_write(2'd0, 8'h0F);
        src_req = 4'b1010;
        tick();
        src_req = '0;
        tick();
        chk("prio_irq1", {7'd0, irq}, 8'h01);
        chk("prio_id1", {6'd0, irq_id}, 8'h01);
        src_req = 4'b0001;          // higher priority arrives during REQ
        tick();
        src_req = '0;
        chk("prio_no_preempt", {6'd0, irq_id}, 8'h01);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        chk_reg("prio_pend_after_ack", 2'd1, 8'h09);
        irq_done = 1'b1;
        tick();
        irq_done = 1'b0;
        chk("prio_irq_idle", {7'd0, irq}, 8'h00);
        tick();
        chk("prio_irq2", {7'd0, irq}, 8'h01);
        chk("prio_id2", {6'd0, irq_id}, 8'h00);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        irq_done = 1'b1;
        tick();
        irq_done = 1'b0;
        tick();
        chk("prio_id3", {6'd0, irq_id}, 8'h03);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        irq_done = 1'b1;
        tick();
        irq_done = 1'b0;
        chk_reg("prio_pend_empty", 2'd1, 8'h00);

        // Masking and GIE
        cfg_write(2'd0, 8'h03);
        src_req = 4'b0100;
        tick();
        src_req = '0;
        tick();
        tick();
        chk("mask_no_irq", {7'd0, irq}, 8'h00);
        chk_reg("mask_pend", 2'd1, 8'h04);
        cfg_write(2'd0, 8'h07);
        chk("mask_irq_not_yet", {7'd0, irq}, 8'h00);
        tick();
        chk("mask_irq_rise", {7'd0, irq}, 8'h01);
        chk("mask_id", {6'd0, irq_id}, 8'h02);
        cfg_write(2'd2, 8'h00);
        chk("gie_irq_still", {7'd0, irq}, 8'h01);
        tick();
        chk("gie_withdraw_irq", {7'd0, irq}, 8'h00);
        chk("gie_withdraw_state", {6'd0, state_dbg}, {6'd0, S_IDLE});
        chk_reg("gie_pend_kept", 2'd1, 8'h04);
        irq_ack = 1'b1;             // ack outside REQ is ignored
        tick();
        irq_ack = 1'b0;
        chk_reg("ack_idle_ignored", 2'd1, 8'h04);
        cfg_write(2'd2, 8'h01);
        tick();
        chk("gie_rerequest", {7'd0, irq}, 8'h01);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        irq_done = 1'b1;
        tick();
        irq_done = 1'b0;

        // Set/clear collision
        cfg_write(2'd0, 8'h00);
        cfg_wr_en = 1'b1;
        cfg_addr  = 2'd1;
        cfg_wdata = 8'h01;
        src_req   = 4'b0001;
        tick();
        cfg_wr_en = 1'b0;
        src_req   = '0;
        chk_reg("coll_w1c_set_wins", 2'd1, 8'h01);
        cfg_write(2'd1, 8'h01);
        chk_reg("coll_w1c_clears", 2'd1, 8'h00);
        cfg_write(2'd0, 8'h01);
        src_req = 4'b0001;
        tick();
        src_req = '0;
        tick();
        chk("coll_irq", {7'd0, irq}, 8'h01);
        irq_ack = 1'b1;
        src_req = 4'b0001;
        tick();
        irq_ack = 1'b0;
        src_req = '0;
        chk_reg("coll_ack_set_wins", 2'd1, 8'h01);
        chk("coll_state_svc", {6'd0, state_dbg}, {6'd0, S_SERVICE});
        irq_done = 1'b1;
        tick();
        irq_done = 1'b0;
        tick();
        chk("coll_second_irq", {7'd0, irq}, 8'h01);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        irq_done = 1'b1;
        tick();
        irq_done = 1'b0;

        // Config outputs and readback
        cfg_write(2'd3, 8'h92);
        cfg_write(2'd2, 8'h51);
        chk("cfg_sense_out", int_sense, 8'h92);
        chk("cfg_debounce_out", {4'd0, int_debounce}, 8'h05);
        chk_reg("cfg_sense_rd", 2'd3, 8'h92);
        chk_reg("cfg_ctrl_rd", 2'd2, 8'h51);
        cfg_write(2'd2, 8'hAF);
        chk_reg("cfg_ctrl_unused", 2'd2, 8'hA1);
        cfg_write(2'd0, 8'hFF);
        chk_reg("cfg_enable_unused", 2'd0, 8'h0F);
        chk("cfg_enable_out", {4'd0, int_enable}, 8'h0F);

        // Reset mid-operation
        cfg_write(2'd0, 8'h02);
        src_req = 4'b0010;
        tick();
        src_req = '0;
        tick();
        chk("rmid_id", {6'd0, irq_id}, 8'h01);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        src_req = 4'b0010;
        tick();
        src_req = '0;
        chk("rmid_state_svc", {6'd0, state_dbg}, {6'd0, S_SERVICE});
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rmid_irq", {7'd0, irq}, 8'h00);
        chk("rmid_irq_id", {6'd0, irq_id}, 8'h00);
        chk("rmid_enable", {4'd0, int_enable}, 8'h00);
        chk("rmid_sense", int_sense, 8'h00);
        chk("rmid_debounce", {4'd0, int_debounce}, 8'h00);
        chk("rmid_state", {6'd0, state_dbg}, {6'd0, S_IDLE});
        chk_reg("rmid_pending", 2'd1, 8'h00);
        chk_reg("rmid_ctrl", 2'd2, 8'h00);
        irq_done = 1'b1;
        tick();
        irq_done = 1'b0;
        tick();
        chk("rmid_done_ignored", {6'd0, state_dbg}, {6'd0, S_IDLE});
        chk("rmid_irq_after", {7'd0, irq}, 8'h00);

        // Final report
        if (exp_q.size() != 0) begin
            n_bad++;
            $error("FAIL scoreboard_leftover: observed %0d entries expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no end of test, expected completion");
        $fatal(1, "timeout");
    end

endmodule
